// File: rtl/zbt_pkg.sv
// Shared ZBT constants, pair-word layout and the pixel-pair addressing used by
// both the write path and the display read path.
package zbt_pkg;

  localparam int PIX_W      = 18;
  localparam int ZBT_ADDR_W = 19;

  typedef struct packed {
    logic [PIX_W-1:0] even;
    logic [PIX_W-1:0] odd;
  } pair_word_t;

  typedef enum logic {
    EMPTY     = 1'b0,
    HAVE_EVEN = 1'b1
  } pack_state_e;

  // Two horizontally adjacent pixels share one word: {row, column>>1}.
  function automatic logic [ZBT_ADDR_W-1:0] pair_addr(input logic [9:0]  y,
                                                      input logic [10:0] x);
    return {y, x[9:1]};
  endfunction

endpackage

// File: rtl/zbt_pair_fifo.sv
// Synchronous FIFO with two ordered push ports and one pop port. The parent
// gates pushes with free_cnt_o, so this block never sees an overflow.
module zbt_pair_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0_i,
  input  logic [WIDTH-1:0] push0_data_i,
  input  logic             push1_i,
  input  logic [WIDTH-1:0] push1_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] free_cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // push1 is only ever asserted together with push0 and lands one slot later.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
    if (push1_i) mem_q[wr_ptr_q + PTR_W'(1)] <= push1_data_i;
  end

  always_comb begin
    count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
      count_q  <= count_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign free_cnt_o = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/zbt_pair_writer.sv
// Packs an (x,y) pixel stream into even/odd pair words and writes them to a ZBT
// bank when granted, with write_data lagging write_we by DATA_LAG cycles.
module zbt_pair_writer #(
  parameter int PIX_W      = zbt_pkg::PIX_W,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_LAG   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic [10:0]          pix_x,
  input  logic [9:0]           pix_y,
  input  logic                 flush,
  input  logic                 write_grant,
  output logic                 write_req,
  output logic                 write_we,
  output logic [18:0]          write_addr,
  output logic [2*PIX_W-1:0]   write_data,
  output logic [7:0]           overflow_cnt,
  output zbt_pkg::pack_state_e pack_state
);
  import zbt_pkg::*;

  localparam int WORD_W  = 2 * PIX_W;
  localparam int ENTRY_W = ZBT_ADDR_W + WORD_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  pack_state_e           state_q, state_d;
  logic [ZBT_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [PIX_W-1:0]      hold_pix_q, hold_pix_d;
  logic [7:0]            ovf_q, ovf_d;
  logic [WORD_W-1:0]     lag_q [DATA_LAG];

  logic [ZBT_ADDR_W-1:0] pix_addr;
  logic [2:0]            cand_v;
  logic [ENTRY_W-1:0]    cand_w [3];
  logic                  req0, req1, push0, push1, pop, fifo_empty;
  logic [ENTRY_W-1:0]    req0_w, req1_w, head;
  logic [CNT_W-1:0]      free_cnt;
  logic [CNT_W:0]        avail;
  logic [1:0]            drops;
  logic [8:0]            ovf_sum;

  assign pix_addr = pair_addr(pix_y, pix_x);

  // Candidate pushes in output order: evicted hold, pixel's own word, flushed hold.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_pix_d  = hold_pix_q;
    cand_v      = '0;
    cand_w      = '{default: '0};
    if (pix_valid) begin
      if (state_q == HAVE_EVEN && pix_x[0] && pix_addr == hold_addr_q) begin
        cand_v[1] = 1'b1;
        cand_w[1] = {hold_addr_q, hold_pix_q, pix_data};
        state_d   = EMPTY;
      end else begin
        if (state_q == HAVE_EVEN) begin
          cand_v[0] = 1'b1;
          cand_w[0] = {hold_addr_q, hold_pix_q, {PIX_W{1'b0}}};
        end
        if (pix_x[0]) begin
          cand_v[1] = 1'b1;
          cand_w[1] = {pix_addr, {PIX_W{1'b0}}, pix_data};
          state_d   = EMPTY;
        end else begin
          state_d     = HAVE_EVEN;
          hold_addr_d = pix_addr;
          hold_pix_d  = pix_data;
        end
      end
    end
    if (flush && state_d == HAVE_EVEN) begin
      cand_v[2] = 1'b1;
      cand_w[2] = {hold_addr_d, hold_pix_d, {PIX_W{1'b0}}};
      state_d   = EMPTY;
    end
  end

  // At most two candidates are ever valid; compact them onto the two FIFO ports.
  always_comb begin
    req0   = 1'b0;
    req1   = 1'b0;
    req0_w = '0;
    req1_w = '0;
    for (int i = 0; i < 3; i++) begin
      if (cand_v[i]) begin
        if (!req0) begin
          req0   = 1'b1;
          req0_w = cand_w[i];
        end else begin
          req1   = 1'b1;
          req1_w = cand_w[i];
        end
      end
    end
  end

  // Handshake: write_req means a word is queued; the arbiter answers with
  // write_grant in the same cycle, and req && grant is the one and only
  // transfer condition (write_we). A same-cycle pop frees a slot for a push.
  assign write_req = !fifo_empty;
  assign pop       = write_req && write_grant && !reset;
  assign avail     = {1'b0, free_cnt} + (CNT_W+1)'(pop);
  assign push0     = req0 && (avail >= (CNT_W+1)'(1));
  assign push1     = req1 && (avail >= (CNT_W+1)'(2));
  assign drops     = 2'(req0 && !push0) + 2'(req1 && !push1);
  assign ovf_sum   = {1'b0, ovf_q} + 9'(drops);
  assign ovf_d     = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];

  zbt_pair_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push0_i      (push0),
    .push0_data_i (req0_w),
    .push1_i      (push1),
    .push1_data_i (req1_w),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .free_cnt_o   (free_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_addr_q <= '0;
      hold_pix_q  <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < DATA_LAG; i++) lag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_pix_q  <= hold_pix_d;
      ovf_q       <= ovf_d;
      lag_q[0]    <= pop ? head[WORD_W-1:0] : '0;
      for (int i = 1; i < DATA_LAG; i++) lag_q[i] <= lag_q[i-1];
    end
  end

  assign write_we     = pop;
  assign write_addr   = pop ? head[ENTRY_W-1 -: ZBT_ADDR_W] : '0;
  assign write_data   = lag_q[DATA_LAG-1];
  assign overflow_cnt = ovf_q;
  assign pack_state   = state_q;

endmodule

// File: tb/tb_zbt_pair_writer.sv
// Bench for zbt_pair_writer: directed scenarios plus random traffic, checked
// by a queue-based scoreboard fed from a pixel-level reference model.
module tb_zbt_pair_writer;
  import zbt_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAG   = 2;
  localparam int WW    = 2 * PIX_W;
  localparam int W     = ZBT_ADDR_W + WW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, pix_valid, flush, write_grant;
  logic [PIX_W-1:0]  pix_data;
  logic [10:0]       pix_x;
  logic [9:0]        pix_y;
  logic              write_req, write_we;
  logic [18:0]       write_addr;
  logic [WW-1:0]     write_data;
  logic [7:0]        overflow_cnt;
  pack_state_e       pack_state;

  zbt_pair_writer #(.PIX_W(PIX_W), .FIFO_DEPTH(DEPTH), .DATA_LAG(LAG)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .flush        (flush),
    .write_grant  (write_grant),
    .write_req    (write_req),
    .write_we     (write_we),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .overflow_cnt (overflow_cnt),
    .pack_state   (pack_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W-1:0]  exp_q[$];
  logic [WW-1:0] data_q[$];
  int            due_q[$];

  // reference model: occupancy, drop count, pending even pixel
  int               occ = 0;
  int               ovf_exp = 0;
  bit               m_have = 0;
  int               m_addr = 0;
  logic [PIX_W-1:0] m_pix = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [W-1:0] mk(input int addr, input logic [PIX_W-1:0] ev,
                                      input logic [PIX_W-1:0] od);
    pair_word_t pw;
    pw.even = ev;
    pw.odd  = od;
    return {ZBT_ADDR_W'(addr), pw};
  endfunction

  // Applies one cycle of stimulus to the model at the clock edge that commits it.
  task automatic commit(input bit rst, input bit v, input logic [PIX_W-1:0] d,
                        input int x, input int y, input bit fl, input bit gr);
    logic [W-1:0] out[$];
    int a;
    if (rst) begin
      occ = 0; ovf_exp = 0; m_have = 0;
      exp_q.delete(); data_q.delete(); due_q.delete();
      return;
    end
    if (occ > 0 && gr) occ--;
    a = y * 512 + (x % 1024) / 2;
    if (v) begin
      if (m_have && (x % 2 == 1) && a == m_addr) begin
        out.push_back(mk(m_addr, m_pix, d));
        m_have = 0;
      end else begin
        if (m_have) out.push_back(mk(m_addr, m_pix, '0));
        if (x % 2 == 1) begin
          out.push_back(mk(a, '0, d));
          m_have = 0;
        end else begin
          m_have = 1; m_addr = a; m_pix = d;
        end
      end
    end
    if (fl && m_have) begin
      out.push_back(mk(m_addr, m_pix, '0));
      m_have = 0;
    end
    foreach (out[i]) begin
      if (occ < DEPTH) begin
        exp_q.push_back(out[i]);
        occ++;
      end else if (ovf_exp < 255) begin
        ovf_exp++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [PIX_W-1:0] d, input int x, input int y,
                      input bit fl, input bit gr, input bit rst = 1'b0);
    reset = rst; pix_valid = v; pix_data = d; pix_x = 11'(x); pix_y = 10'(y);
    flush = fl; write_grant = gr;
    @(posedge clk);
    commit(rst, v, d, x, y, fl, gr);
    #1;
  endtask

  task automatic idle(input int n, input bit gr);
    repeat (n) step(1'b0, '0, 0, 0, 1'b0, gr);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || due_q.size() != 0); i++) idle(1, 1'b1);
    check("drain_empty", 64'(exp_q.size() + due_q.size()), 64'(0));
  endtask

  // ---------------- monitor ----------------
  bit            mon_req, mon_we;
  logic [W-1:0]  mon_e;
  logic [WW-1:0] mon_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("we_in_reset", 64'(write_we), 64'(0));
    end else begin
      mon_req  = (exp_q.size() != 0);
      mon_we   = mon_req && write_grant;
      mon_data = '0;
      check("write_req", 64'(write_req), 64'(mon_req));
      check("write_we", 64'(write_we), 64'(mon_we));
      if (mon_we) begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(write_addr), 64'(mon_e[W-1 -: ZBT_ADDR_W]));
        data_q.push_back(mon_e[WW-1:0]);
        due_q.push_back(cyc + LAG);
      end else begin
        check("write_addr_idle", 64'(write_addr), 64'(0));
      end
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        mon_data = data_q.pop_front();
        void'(due_q.pop_front());
      end
      check("write_data", 64'(write_data), 64'(mon_data));
      check("overflow_cnt", 64'(overflow_cnt), 64'(ovf_exp));
      check("pack_state", 64'(pack_state == HAVE_EVEN), 64'(m_have));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    step(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1);

    // simple pair at row 5: address 0x00A00, data 0x000440022
    step(1'b1, 18'h00011, 0, 5, 1'b0, 1'b1);
    step(1'b1, 18'h00022, 1, 5, 1'b0, 1'b1);
    idle(4, 1'b1);

    // lone even x=4 evicted by x=6, flush, then lone odd x=9
    step(1'b1, 18'h00444, 4, 7, 1'b0, 1'b1);
    step(1'b1, 18'h00666, 6, 7, 1'b0, 1'b1);
    step(1'b0, '0, 0, 0, 1'b1, 1'b1);
    step(1'b1, 18'h00999, 9, 7, 1'b0, 1'b1);
    idle(4, 1'b1);

    // six pairs with no grant: four kept, two dropped
    for (int i = 0; i < 6; i++) begin
      step(1'b1, PIX_W'($urandom), 2 * i,     3, 1'b0, 1'b0);
      step(1'b1, PIX_W'($urandom), 2 * i + 1, 3, 1'b0, 1'b0);
    end
    idle(2, 1'b0);
    check("burst_overflow", 64'(overflow_cnt), 64'(2));
    check("burst_req", 64'(write_req), 64'(1));
    idle(6, 1'b1);

    // flush plus even pixel at a new address while holding: two ordered pushes
    step(1'b1, 18'h000AA, 10, 8, 1'b0, 1'b0);
    step(1'b1, 18'h000BB, 20, 8, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(4, 1'b1);

    // reset with three words queued and one word in the lag pipe
    for (int i = 0; i < 4; i++) begin
      step(1'b1, PIX_W'($urandom), 2 * i,     9, 1'b0, 1'b0);
      step(1'b1, PIX_W'($urandom), 2 * i + 1, 9, 1'b0, 1'b0);
    end
    idle(1, 1'b1);
    step(1'b0, '0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle(6, 1'b1);

    // alternating grant over eight pairs
    for (int i = 0; i < 8; i++) begin
      step(1'b1, PIX_W'($urandom), 2 * i,     11, 1'b0, 1'b1);
      step(1'b1, PIX_W'($urandom), 2 * i + 1, 11, 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) idle(1, 1'(i % 2));
    drain();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      int x;
      x = $urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? 1024 : 0);
      step(1'($urandom_range(0, 3) != 0), PIX_W'($urandom), x, $urandom_range(0, 3),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 199) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
